// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU data-memory path.
package cpu_mem_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned WORD_ADDR_W   = 30;

    // One buffered store: word address plus full data word.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word_addr;
        logic [31:0]            data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward_match.sv
// Store-to-load forwarding search: finds the youngest valid entry matching a word address.
module sb_forward_match
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t              entries [DEPTH],
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       tail,
    input  logic [WORD_ADDR_W-1:0] word_addr,
    output logic                   hit,
    output logic [31:0]            data
);

    // Walk oldest to youngest so the youngest match is the last one to win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        hit  = 1'b0;
        data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (valid[idx] && (entries[idx].word_addr == word_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-posting store buffer: single-cycle CPU stores into a FIFO that drains over req/ack,
// with load forwarding from pending stores.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [31:0] cpu_read_data,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_req,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    input  logic        mem_write_ack,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, push;
    logic [DEPTH-1:0] valid;
    logic             fwd_hit;
    logic [31:0]      fwd_data;

    assign empty          = (count_q == '0);
    assign full           = (count_q == CNT_W'(DEPTH));
    assign overflow       = overflow_q;
    assign mem_write_req  = !empty;
    assign mem_write_addr = {mem_q[head_q].word_addr, 2'b00};
    assign mem_write_data = mem_q[head_q].data;
    assign mem_read_addr  = cpu_addr;

    // A full buffer still accepts a store when the head drains in the same cycle.
    assign pop  = mem_write_req && mem_write_ack;
    assign push = cpu_write_en && (!full || pop);

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = overflow_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (cpu_write_en && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are meaningless outside the valid window, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{word_addr: cpu_addr[31:2], data: cpu_write_data};
        end
    end

    // Entry i is valid when its distance from head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        valid  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - head_q;
            valid[i] = (CNT_W'(offset) < count_q);
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_forward (
        .entries   (mem_q),
        .valid     (valid),
        .tail      (tail_q),
        .word_addr (cpu_addr[31:2]),
        .hit       (fwd_hit),
        .data      (fwd_data)
    );

    // Loads prefer the youngest pending store to the same word.
    always_comb begin
        cpu_read_data = mem_read_data;
        if (cpu_read_en && fwd_hit) begin
            cpu_read_data = fwd_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed stimulus with a drain scoreboard.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [31:0] cpu_read_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_req;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_ack;
    logic        full;
    logic        empty;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    // Expected drain sequence: {addr, data}.
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_read_en    (cpu_read_en),
        .cpu_write_en   (cpu_write_en),
        .cpu_read_data  (cpu_read_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_ack  (mem_write_ack),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store; expect it to be accepted and drained later.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        cpu_addr       = addr;
        cpu_write_data = data;
        cpu_write_en   = 1'b1;
        exp_q.push_back({addr & 32'hFFFF_FFFC, data});
        tick();
        cpu_write_en = 1'b0;
    endtask

    // Drain monitor: every accepted handshake must match the oldest expected store.
    always @(negedge clk) begin
        if (!rst && mem_write_req && mem_write_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL drain_unexpected: got addr %h with no store pending, required none",
                         mem_write_addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("drain_addr", mem_write_addr, e[63:32]);
                check("drain_data", mem_write_data, e[31:0]);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        cpu_addr       = '0;
        cpu_write_data = '0;
        cpu_read_en    = 1'b0;
        cpu_write_en   = 1'b0;
        mem_read_data  = '0;
        mem_write_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_req", 32'(mem_write_req), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Single store held while ack is low, then drained.
        store(32'h100, 32'hAAAA_0001);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_req", 32'(mem_write_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t1_hold_addr", mem_write_addr, 32'h100);
            check("t1_hold_data", mem_write_data, 32'hAAAA_0001);
            tick();
        end
        mem_write_ack = 1'b1;
        tick();
        mem_write_ack = 1'b0;
        check("t1_empty_after", 32'(empty), 32'd1);

        // Forwarding picks the youngest store; unrelated address reads memory.
        store(32'h200, 32'd1);
        store(32'h200, 32'd2);
        mem_read_data = 32'hDEAD;
        cpu_read_en   = 1'b1;
        cpu_addr      = 32'h203;
        #1;
        check("t2_fwd_youngest", cpu_read_data, 32'd2);
        cpu_addr = 32'h300;
        #1;
        check("t2_miss", cpu_read_data, 32'hDEAD);
        cpu_read_en = 1'b0;
        cpu_addr    = 32'h200;
        #1;
        check("t2_no_read_en", cpu_read_data, 32'hDEAD);
        mem_write_ack = 1'b1;
        tick();
        tick();
        mem_write_ack = 1'b0;
        check("t2_empty", 32'(empty), 32'd1);

        // Overflow: fifth store dropped, flag sticky, drain order preserved.
        for (int i = 0; i < 4; i++) begin
            store(32'h400 + 32'(i * 4), 32'h30 + 32'(i));
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_no_overflow_yet", 32'(overflow), 32'd0);
        cpu_addr       = 32'h410;
        cpu_write_data = 32'h34;
        cpu_write_en   = 1'b1;
        tick();
        cpu_write_en = 1'b0;
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_still_full", 32'(full), 32'd1);
        mem_write_ack = 1'b1;
        repeat (4) tick();
        mem_write_ack = 1'b0;
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous store and drain, repeated so pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                store(32'h1000 + 32'(r * 64 + i * 4), 32'hC000_0000 + 32'(r * 16 + i));
            end
            check("t4_full", 32'(full), 32'd1);
            cpu_addr       = 32'h2000 + 32'(r * 4);
            cpu_write_data = 32'hD000_0000 + 32'(r);
            cpu_write_en   = 1'b1;
            mem_write_ack  = 1'b1;
            exp_q.push_back({cpu_addr, cpu_write_data});
            tick();
            cpu_write_en  = 1'b0;
            mem_write_ack = 1'b0;
            check("t4_full_kept", 32'(full), 32'd1);
            check("t4_no_overflow", 32'(overflow), 32'd0);
            mem_write_ack = 1'b1;
            repeat (4) tick();
            mem_write_ack = 1'b0;
            check("t4_empty", 32'(empty), 32'd1);
        end

        // Reset discards pending stores.
        store(32'h500, 32'h51);
        store(32'h504, 32'h52);
        store(32'h508, 32'h53);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t5_req", 32'(mem_write_req), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd0);
        mem_read_data = 32'hBEEF;
        cpu_read_en   = 1'b1;
        cpu_addr      = 32'h504;
        #1;
        check("t5_load_mem", cpu_read_data, 32'hBEEF);
        cpu_read_en = 1'b0;

        // Entry popped this cycle still forwards; next cycle reads memory.
        store(32'h600, 32'h66);
        mem_read_data = 32'h1234;
        cpu_read_en   = 1'b1;
        cpu_addr      = 32'h600;
        mem_write_ack = 1'b1;
        #1;
        check("t6_fwd_popping", cpu_read_data, 32'h66);
        tick();
        mem_write_ack = 1'b0;
        check("t6_after_pop", cpu_read_data, 32'h1234);
        cpu_read_en = 1'b0;

        tick();
        check("sb_all_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
